// File: rtl/mmul2_pkg.sv
// ============================================================================
// mmul2_pkg : shared types and helpers for the mmul2 operand feeder
// Revision  : 1.0
// ============================================================================
`default_nettype none

package mmul2_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } mmul2_feeder_state_t;

   // Slot counter width for an n-entry matrix, never narrower than one bit.
   function automatic int idx_w(int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mmul2_feeder.sv
// ============================================================================
// mmul2_feeder : streams A then B into flat row-major buses, then runs mmul2
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mmul2_feeder
   import mmul2_pkg::*;
#(
   parameter int RA = 2,
   parameter int CA = 2,
   parameter int RB = 2,
   parameter int CB = 2,
   parameter int W  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [W-1:0]          s_data,
   input  logic                  s_last,
   output logic [RA*CA*W-1:0]    A,
   output logic [RB*CB*W-1:0]    B,
   output logic                  enable,
   input  logic                  completed,
   output logic                  busy,
   output logic                  err
);

   localparam int NA    = RA * CA;
   localparam int NB    = RB * CB;
   localparam int IDX_W = idx_w((NA > NB) ? NA : NB);

   localparam logic [IDX_W-1:0] A_LAST = IDX_W'(NA - 1);
   localparam logic [IDX_W-1:0] B_LAST = IDX_W'(NB - 1);

   if (CA != RB) begin : g_dim_check
      $fatal(1, "mmul2_feeder: CA (%0d) must equal RB (%0d)", CA, RB);
   end

   mmul2_feeder_state_t   state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NA*W-1:0]       a_q, a_d;
   logic [NB*W-1:0]       b_q, b_d;
   logic                  err_q, err_d;
   logic                  first_q, first_d;
   logic                  xfer;

   assign s_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign enable  = (state_q == RUN);
   assign busy    = (state_q == RUN) || (state_q == DONE);
   assign err     = err_q;
   assign A       = a_q;
   assign B       = b_q;
   assign xfer    = s_valid && s_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      err_d   = err_q;
      first_d = 1'b0;

      case (state_q)
         LOAD_A: begin
            if (xfer) begin
               for (int i = 0; i < NA; i++) begin
                  if (idx_q == IDX_W'(i)) a_d[i*W +: W] = s_data;
               end
               if (s_last) begin
                  err_d = 1'b1;
                  idx_d = '0;
               end else if (idx_q == A_LAST) begin
                  idx_d   = '0;
                  state_d = LOAD_B;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         LOAD_B: begin
            if (xfer) begin
               for (int i = 0; i < NB; i++) begin
                  if (idx_q == IDX_W'(i)) b_d[i*W +: W] = s_data;
               end
               if (idx_q == B_LAST) begin
                  idx_d = '0;
                  if (s_last) begin
                     state_d = RUN;
                     first_d = 1'b1;
                  end else begin
                     err_d   = 1'b1;
                     state_d = LOAD_A;
                  end
               end else if (s_last) begin
                  err_d   = 1'b1;
                  idx_d   = '0;
                  state_d = LOAD_A;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         RUN: begin
            // completed may still be high from the previous operation on entry
            if (!first_q && completed) state_d = DONE;
         end

         DONE: begin
            state_d = LOAD_A;
            idx_d   = '0;
         end

         default: begin
            state_d = LOAD_A;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD_A;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= 1'b0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         first_q <= first_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mmul2_feeder.sv
// ============================================================================
// tb_mmul2_feeder : directed self-checking bench for mmul2_feeder (2x2, W=8)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mmul2_feeder;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data;
   logic          s_last;
   logic [31:0]   A;
   logic [31:0]   B;
   logic          enable;
   logic          completed;
   logic          busy;
   logic          err;

   int n_cmp  = 0;
   int n_fail = 0;

   mmul2_feeder #(.RA(2), .CA(2), .RB(2), .CB(2), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .A         (A),
      .B         (B),
      .enable    (enable),
      .completed (completed),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Ends a RUN: one cycle past the ignored first cycle, then completed, DONE, LOAD_A.
   task automatic finish_run();
      step();
      completed = 1'b1;
      step();
      completed = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; completed = 1'b0;
      step();
      step();
      rst = 1'b0;
      n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
      n_cmp++; if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%b exp=0", enable); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
      n_cmp++; if (A !== 32'h0) begin n_fail++; $display("FAIL reset_A got=%h exp=00000000", A); end
      n_cmp++; if (B !== 32'h0) begin n_fail++; $display("FAIL reset_B got=%h exp=00000000", B); end
   endtask

   task automatic test_basic_load();
      send(8'd1, 1'b0);
      n_cmp++; if (A !== 32'h00000001) begin n_fail++; $display("FAIL basic_first_write got=%h exp=00000001", A); end
      send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
      n_cmp++; if (B !== 32'h0) begin n_fail++; $display("FAIL basic_B_untouched got=%h exp=00000000", B); end
      send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b0);
      n_cmp++; if (enable !== 1'b0) begin n_fail++; $display("FAIL basic_enable_early got=%b exp=0", enable); end
      send(8'd8, 1'b1);
      n_cmp++; if (A !== 32'h04030201) begin n_fail++; $display("FAIL basic_A got=%h exp=04030201", A); end
      n_cmp++; if (B !== 32'h08070605) begin n_fail++; $display("FAIL basic_B got=%h exp=08070605", B); end
      n_cmp++; if (enable !== 1'b1) begin n_fail++; $display("FAIL basic_enable got=%b exp=1", enable); end
      n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL basic_s_ready_run got=%b exp=0", s_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
   endtask

   // Entered in RUN cycle 1 straight after test_basic_load.
   task automatic test_run_complete();
      completed = 1'b1;
      s_valid = 1'b1; s_data = 8'hFF;
      step();
      completed = 1'b0;
      n_cmp++; if (enable !== 1'b1) begin n_fail++; $display("FAIL run_first_cycle_ignored got=%b exp=1", enable); end
      for (int c = 2; c <= 4; c++) begin
         step();
         n_cmp++; if (enable !== 1'b1) begin n_fail++; $display("FAIL run_enable_c%0d got=%b exp=1", c + 1, enable); end
         n_cmp++; if ({A, B} !== 64'h04030201_08070605) begin n_fail++; $display("FAIL run_operands_stable got=%h exp=0403020108070605", {A, B}); end
      end
      s_valid = 1'b0;
      completed = 1'b1;
      step();
      completed = 1'b0;
      n_cmp++; if (enable !== 1'b0) begin n_fail++; $display("FAIL done_enable got=%b exp=0", enable); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_busy got=%b exp=1", busy); end
      n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL done_s_ready got=%b exp=0", s_ready); end
      step();
      n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rearm_s_ready got=%b exp=1", s_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rearm_busy got=%b exp=0", busy); end
      n_cmp++; if ({A, B} !== 64'h04030201_08070605) begin n_fail++; $display("FAIL rearm_operands got=%h exp=0403020108070605", {A, B}); end
   endtask

   task automatic test_backpressure();
      int cyc;
      cyc = 0;
      send(8'h11, 1'b0); cyc++;
      send(8'h22, 1'b0); cyc++;
      s_data = 8'hEE;
      for (int g = 0; g < 3; g++) begin
         step(); cyc++;
         n_cmp++; if (A !== 32'h04032211) begin n_fail++; $display("FAIL gap_no_write got=%h exp=04032211", A); end
      end
      send(8'h33, 1'b0); cyc++;
      send(8'h44, 1'b0); cyc++;
      send(8'h55, 1'b0); cyc++;
      send(8'h66, 1'b0); cyc++;
      send(8'h77, 1'b0); cyc++;
      n_cmp++; if (enable !== 1'b0) begin n_fail++; $display("FAIL gap_enable_early got=%b exp=0 at cycle %0d", enable, cyc); end
      send(8'h88, 1'b1); cyc++;
      n_cmp++; if (enable !== 1'b1 || cyc != 11) begin n_fail++; $display("FAIL gap_enable_timing got=%b@%0d exp=1@11", enable, cyc); end
      n_cmp++; if (A !== 32'h44332211) begin n_fail++; $display("FAIL gap_A got=%h exp=44332211", A); end
      n_cmp++; if (B !== 32'h88776655) begin n_fail++; $display("FAIL gap_B got=%h exp=88776655", B); end
      finish_run();
   endtask

   task automatic test_early_last();
      send(8'h91, 1'b0); send(8'h92, 1'b0); send(8'h93, 1'b1);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL early_err got=%b exp=1", err); end
      n_cmp++; if (s_ready !== 1'b1 || enable !== 1'b0) begin n_fail++; $display("FAIL early_state got=rdy%b en%b exp=rdy1 en0", s_ready, enable); end
      send(8'hA0, 1'b0); send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
      send(8'hB0, 1'b0); send(8'hB1, 1'b0); send(8'hB2, 1'b0); send(8'hB3, 1'b1);
      n_cmp++; if (A !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL early_reload_A got=%h exp=a3a2a1a0", A); end
      n_cmp++; if (B !== 32'hB3B2B1B0) begin n_fail++; $display("FAIL early_reload_B got=%h exp=b3b2b1b0", B); end
      n_cmp++; if (enable !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL early_reload_run got=en%b err%b exp=en1 err1", enable, err); end
      finish_run();
   endtask

   task automatic test_missing_last();
      do_reset();
      for (int i = 0; i < 8; i++) send(8'hD0 + 8'(i), 1'b0);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL missing_err got=%b exp=1", err); end
      n_cmp++; if (B !== 32'hD7D6D5D4) begin n_fail++; $display("FAIL missing_B got=%h exp=d7d6d5d4", B); end
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (enable !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL missing_no_run got=en%b rdy%b exp=en0 rdy1", enable, s_ready); end
         step();
      end
      send(8'hC1, 1'b0);
      n_cmp++; if (A !== 32'hD3D2D1C1) begin n_fail++; $display("FAIL missing_idx_zero got=%h exp=d3d2d1c1", A); end
   endtask

   // Continues the pair started at the end of test_missing_last (A slot 0 holds C1).
   task automatic test_reset_mid_run();
      send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
      send(8'hC5, 1'b0); send(8'hC6, 1'b0); send(8'hC7, 1'b0); send(8'hC8, 1'b1);
      n_cmp++; if (enable !== 1'b1 || A !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL prerst_run got=en%b A=%h exp=en1 A=c4c3c2c1", enable, A); end
      step();
      do_reset();
      n_cmp++; if (enable !== 1'b0) begin n_fail++; $display("FAIL rst_run_enable got=%b exp=0", enable); end
      n_cmp++; if (A !== 32'h0 || B !== 32'h0) begin n_fail++; $display("FAIL rst_run_operands got=A%h B%h exp=0", A, B); end
      n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_run_s_ready got=%b exp=1", s_ready); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_run_err got=%b exp=0", err); end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_run_complete();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mmul2_feeder.md
# mmul2_feeder

Stream-side loader for the `mmul2` matrix multiplier. It accepts matrix elements one per handshake over a valid/ready stream, assembles them into the flat row-major `A` and `B` buses, and holds `enable` until the multiplier reports `completed`. It then re-arms for the next operand pair. It sits between the host/DMA stream and `mmul2`, on the producer end of `mmul2`'s operand interface.

## Interface

- `RA`, default 2: rows of A.
- `CA`, default 2: columns of A; must equal `RB` (elaboration-time `$fatal` otherwise).
- `RB`, default 2: rows of B.
- `CB`, default 2: columns of B.
- `W`, default 32: element bit width.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: stream element valid.
- `s_ready` out 1: feeder can accept an element.
- `s_data` in W: element value, unsigned.
- `s_last` in 1: marks the final element of B (the last element of the operand pair).
- `A` out RA\*CA\*W: matrix A, element (r,c) at `[W*(r*CA+c) +: W]`.
- `B` out RB\*CB\*W: matrix B, element (r,c) at `[W*(r*CB+c) +: W]`.
- `enable` out 1: drives `mmul2.enable`.
- `completed` in 1: from `mmul2.completed`.
- `busy` out 1: high in RUN and DONE.
- `err` out 1: sticky framing error; cleared only by `rst`.

## Operation

- States: LOAD_A, LOAD_B, RUN, DONE. Reset state is LOAD_A.
- Handshake: a transfer occurs on a rising edge where `s_valid && s_ready`. `s_data` is ignored otherwise.
- LOAD_A:
  - Each transfer writes `s_data` to A slot `idx`, then increments `idx` (row-major, 0..RA\*CA-1).
  - The transfer at `idx == RA*CA-1` clears `idx` and moves to LOAD_B.
- LOAD_B:
  - Each transfer writes `s_data` to B slot `idx` (0..RB\*CB-1).
  - On the final slot with `s_last=1`: go to RUN.
- Framing errors:
  - `s_last=1` on any transfer other than the final B slot sets `err`. The element is written, then `idx` clears and the state returns to LOAD_A; the partial pair is discarded.
  - `s_last=0` on the final B slot sets `err`. The element is written, the state returns to LOAD_A, and RUN is never entered.
- RUN:
  - `enable=1`, `s_ready=0`. `A` and `B` are held stable.
  - `completed` is ignored during the first RUN cycle; the multiplier's flag may be stale from the previous operation.
  - `completed=1` on any later cycle moves the state to DONE.
- DONE: one cycle with `enable=0`, then LOAD_A with `idx=0`.
- `idx` width is `$clog2(max(RA*CA, RB*CB))`, minimum 1. `idx` never exceeds the last slot of the current matrix.
- Reset mid-operation, from any state:
  - Next cycle: LOAD_A, `idx=0`, `enable=0`.
  - `A` and `B` are zeroed; `err=0`.

## Timing

- Reset values: `s_ready=1` (LOAD_A), `enable=0`, `busy=0`, `err=0`, `A=0`, `B=0`.
- `s_ready` is a decode of the registered state: 1 in LOAD_A and LOAD_B, 0 in RUN and DONE. It has no combinational path from `s_valid`.
- Throughput: one element per cycle while loading. A full pair takes RA\*CA + RB\*CB transfer cycles minimum.
- Written elements are visible on `A`/`B` the cycle after their handshake.
- `enable` rises the cycle after the final-B handshake.
- `enable` falls the cycle after the first qualifying `completed=1`.
- `s_ready` returns 2 cycles after that `completed` sample: 1 cycle in DONE, then LOAD_A.
- `busy` equals `enable` OR (state == DONE).

## Structure

- Package `mmul2_pkg`: state enum `mmul2_feeder_state_t` {LOAD_A, LOAD_B, RUN, DONE}, and a `function automatic idx_w(int n)` helper.
- No sub-module. The block is a single FSM plus one slot counter and two operand registers.
- Top-level integration instantiates `mmul2_feeder` and `mmul2` side by side.

## Test plan

All scenarios use RA=CA=RB=CB=2, W=8.

- **Basic load:** stream 1,2,3,4 then 5,6,7,8 with `s_last` on the 8th element and `s_valid` held high. Expect `A=0x04030201`, `B=0x08070605`, and `enable=1` on the cycle after the 8th handshake.
- **Backpressure/gaps:** drop `s_valid` for 3 cycles mid-A. Expect no writes during the gap, identical final `A`/`B`, and `enable` delayed by exactly 3 cycles.
- **Run/complete:**
  - Hold `completed=1` during the first RUN cycle; expect it to be ignored.
  - Assert `completed=1` on RUN cycle 5. Expect `enable=0` at cycle 6, `s_ready=1` at cycle 7, and `A`/`B` unchanged throughout RUN.
- **Early `s_last`:** assert `s_last` on the 3rd element. Expect `err=1`, return to LOAD_A with `idx=0`, and no `enable`. A following correct 8-element stream loads normally with `err` still 1.
- **Missing `s_last`:** send 8 elements with `s_last=0`. Expect `err=1`, `enable` never asserted, and the state back in LOAD_A.
- **Reset mid-RUN:** assert `rst` for 1 cycle while `enable=1`. The next cycle shows `enable=0`, `A=B=0`, `s_ready=1`, `err=0`.
